// File: rtl/std_mem_d1_reader.sv
// Read-side initiator for a std_mem_d1 memory. On a go/done handshake it
// streams len words starting at base onto a registered valid/ready output.
module std_mem_d1_reader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   len,
  output logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    read_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [IDX_SIZE+1:0] SizeW = (IDX_SIZE+2)'(SIZE);

  state_t              state_q, state_d;
  logic [IDX_SIZE-1:0] ptr_q, ptr_d;
  logic [IDX_SIZE:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;

  logic [IDX_SIZE+1:0] endAddr;
  logic                outOfBounds;
  logic                slotFree;
  logic                load;

  // Extra headroom bits keep base+len from wrapping before the bounds compare.
  assign endAddr     = {2'b00, base} + {1'b0, len};
  assign outOfBounds = endAddr > SizeW;
  assign slotFree    = !out_valid_q || out_ready;
  assign load        = (state_q == STREAM) && (remaining_q != '0) && slotFree;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          err_d = 1'b0;
          if (len == '0) begin
            state_d = DONE;
          end else if (outOfBounds) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            ptr_d       = base;
            remaining_d = len;
            state_d     = STREAM;
          end
        end
      end
      STREAM: begin
        // A handshake and the next load share a cycle, giving one word per cycle.
        if (load) begin
          out_data_d  = read_data;
          out_valid_d = 1'b1;
          ptr_d       = ptr_q + IDX_SIZE'(1);
          remaining_d = remaining_q - (IDX_SIZE+1)'(1);
        end else if (remaining_q == '0 && slotFree) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign addr0     = (state_q == STREAM) ? ptr_q : '0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule
